// File: rtl/lfm_echo_gen.sv
// lfm_echo_gen: coherent-dwell LFM echo stimulus source for the radar receive chain.
// Each dwell is n_prf PRIs of n_LFM*r_prf samples. Every PRI carries a delayed
// chirp with a per-PRI Doppler phase rotation, on top of a constant clutter level on I.
// Output pipeline: stage 1 registers the ROM addresses, stage 2 the ROM data plus sums.
// The quarter-wave ROM holds round(1023*sin(i*pi/128)), i.e. amplitude for width=12.
// Optional feature macro: LFM_ECHO_NOISE_EN (adds 4-bit LFSR noise to I and Q).
module lfm_echo_gen #(
    parameter int          width       = 12,
    parameter int          n_LFM       = 64,
    parameter int          r_prf       = 8,
    parameter int          n_prf       = 16,
    parameter logic [15:0] F0          = 16'h0400,
    parameter logic [15:0] K_RATE      = 16'h0020,
    parameter int          CLUTTER_AMP = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [13:0]             tgt_delay,
    input  logic [15:0]             doppler_step,
    output logic signed [width-1:0] signal_I,
    output logic signed [width-1:0] signal_Q,
    output logic                    rec_flag,
    output logic [7:0]              pri_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int PRI_LEN = n_LFM * r_prf;
    localparam int S_W     = $clog2(PRI_LEN);
    localparam int P_W     = $clog2(n_prf);
    localparam logic [S_W-1:0] S_LAST  = S_W'(PRI_LEN - 1);
    localparam logic [P_W-1:0] P_LAST  = P_W'(n_prf - 1);
    localparam logic [S_W-1:0] D_MAX   = S_W'(PRI_LEN - n_LFM);
    localparam logic [S_W:0]   WIN_LEN = (S_W + 1)'(n_LFM);
    localparam logic signed [width-1:0] CLUT = width'(CLUTTER_AMP);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, GAP = 2'd3} state_t;

    // Quarter-wave sine ROM, entries 0..64.
    function automatic logic [9:0] qrom(input logic [6:0] a);
        logic [9:0] v;
        case (a)
            7'd0:  v = 10'd0;    7'd1:  v = 10'd25;   7'd2:  v = 10'd50;   7'd3:  v = 10'd75;
            7'd4:  v = 10'd100;  7'd5:  v = 10'd125;  7'd6:  v = 10'd150;  7'd7:  v = 10'd175;
            7'd8:  v = 10'd200;  7'd9:  v = 10'd224;  7'd10: v = 10'd249;  7'd11: v = 10'd273;
            7'd12: v = 10'd297;  7'd13: v = 10'd321;  7'd14: v = 10'd345;  7'd15: v = 10'd368;
            7'd16: v = 10'd391;  7'd17: v = 10'd415;  7'd18: v = 10'd437;  7'd19: v = 10'd460;
            7'd20: v = 10'd482;  7'd21: v = 10'd504;  7'd22: v = 10'd526;  7'd23: v = 10'd547;
            7'd24: v = 10'd568;  7'd25: v = 10'd589;  7'd26: v = 10'd609;  7'd27: v = 10'd629;
            7'd28: v = 10'd649;  7'd29: v = 10'd668;  7'd30: v = 10'd687;  7'd31: v = 10'd705;
            7'd32: v = 10'd723;  7'd33: v = 10'd741;  7'd34: v = 10'd758;  7'd35: v = 10'd775;
            7'd36: v = 10'd791;  7'd37: v = 10'd806;  7'd38: v = 10'd822;  7'd39: v = 10'd836;
            7'd40: v = 10'd851;  7'd41: v = 10'd864;  7'd42: v = 10'd877;  7'd43: v = 10'd890;
            7'd44: v = 10'd902;  7'd45: v = 10'd914;  7'd46: v = 10'd925;  7'd47: v = 10'd935;
            7'd48: v = 10'd945;  7'd49: v = 10'd954;  7'd50: v = 10'd963;  7'd51: v = 10'd971;
            7'd52: v = 10'd979;  7'd53: v = 10'd986;  7'd54: v = 10'd992;  7'd55: v = 10'd998;
            7'd56: v = 10'd1003; 7'd57: v = 10'd1008; 7'd58: v = 10'd1012; 7'd59: v = 10'd1015;
            7'd60: v = 10'd1018; 7'd61: v = 10'd1020; 7'd62: v = 10'd1022; 7'd63: v = 10'd1023;
            7'd64: v = 10'd1023;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    // Full-wave sine from the top phase byte: quadrant in [7:6], ROM index in [5:0].
    function automatic logic signed [width-1:0] sine_of(input logic [7:0] ph_hi);
        logic [6:0]             a;
        logic signed [width-1:0] mag;
        if (ph_hi[6]) begin
            a = 7'd64 - {1'b0, ph_hi[5:0]};
        end else begin
            a = {1'b0, ph_hi[5:0]};
        end
        mag = {{(width - 10){1'b0}}, qrom(a)};
        if (ph_hi[7]) begin
            return -mag;
        end else begin
            return mag;
        end
    endfunction

`ifdef LFM_ECHO_NOISE_EN
    // Galois LFSR step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    state_t           state_r, next_state_s;
    logic             ph_cnt_r;
    logic [S_W-1:0]   s_r, delay_r;
    logic [P_W-1:0]   p_r;
    logic [15:0]      dstep_r, pri_ph_r, ph_acc_r, fr_r;
    logic             win_s;
    logic [15:0]      cur_ph_s, cur_fr_s;
    logic             valid1_r, win1_r;
    logic [7:0]       sin_hi1_r, cos_hi1_r;
    logic [P_W-1:0]   pri1_r;
    logic signed [width-1:0] noise_i_s, noise_q_s;
`ifdef LFM_ECHO_NOISE_EN
    logic [15:0]      lfsr_r;
`endif

    // Next-state logic plus the echo-window phase/frequency selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:  if (start) next_state_s = RUN; else next_state_s = IDLE;
            RUN:   if (s_r == S_LAST && p_r == P_LAST) next_state_s = FLUSH; else next_state_s = RUN;
            FLUSH: if (ph_cnt_r) next_state_s = GAP; else next_state_s = FLUSH;
            GAP:   if (ph_cnt_r) next_state_s = IDLE; else next_state_s = GAP;
            default: next_state_s = IDLE;
        endcase
        win_s = (s_r >= delay_r) && ({1'b0, s_r} < ({1'b0, delay_r} + WIN_LEN));
        if (s_r == delay_r) begin
            cur_ph_s = pri_ph_r;
            cur_fr_s = F0;
        end else begin
            cur_ph_s = ph_acc_r;
            cur_fr_s = fr_r;
        end
    end

    // Noise contribution (zero unless the noise option is built in).
    always_comb begin
`ifdef LFM_ECHO_NOISE_EN
        noise_i_s = {{(width - 4){lfsr_r[3]}}, lfsr_r[3:0]};
        noise_q_s = {{(width - 4){lfsr_r[7]}}, lfsr_r[7:4]};
`else
        noise_i_s = {width{1'b0}};
        noise_q_s = {width{1'b0}};
`endif
    end

    // State register and two-cycle phase counter for FLUSH/GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ph_cnt_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r || state_r == IDLE || state_r == RUN) begin
                ph_cnt_r <= 1'b0;
            end else begin
                ph_cnt_r <= ~ph_cnt_r;
            end
        end
    end

    // Dwell counters, latched request parameters and chirp phase accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r      <= {S_W{1'b0}};
            p_r      <= {P_W{1'b0}};
            delay_r  <= {S_W{1'b0}};
            dstep_r  <= 16'h0000;
            pri_ph_r <= 16'h0000;
            ph_acc_r <= 16'h0000;
            fr_r     <= 16'h0000;
        end else if (state_r == IDLE) begin
            if (start) begin
                dstep_r  <= doppler_step;
                delay_r  <= (tgt_delay > {{(14 - S_W){1'b0}}, D_MAX}) ? D_MAX : tgt_delay[S_W-1:0];
                s_r      <= {S_W{1'b0}};
                p_r      <= {P_W{1'b0}};
                pri_ph_r <= 16'h0000;
            end else begin
                s_r <= s_r;
            end
        end else if (state_r == RUN) begin
            if (s_r == S_LAST) begin
                s_r      <= {S_W{1'b0}};
                p_r      <= p_r + P_W'(1);
                pri_ph_r <= pri_ph_r + dstep_r;
            end else begin
                s_r <= s_r + S_W'(1);
            end
            if (win_s) begin
                ph_acc_r <= cur_ph_s + cur_fr_s;
                fr_r     <= cur_fr_s + K_RATE;
            end else begin
                fr_r <= fr_r;
            end
        end else begin
            s_r <= s_r;
        end
    end

    // Stage 1: ROM addresses for sin and cos, plus alignment flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_r  <= 1'b0;
            win1_r    <= 1'b0;
            sin_hi1_r <= 8'h00;
            cos_hi1_r <= 8'h00;
            pri1_r    <= {P_W{1'b0}};
        end else begin
            valid1_r  <= (state_r == RUN);
            win1_r    <= (state_r == RUN) && win_s;
            sin_hi1_r <= cur_ph_s[15:8];
            cos_hi1_r <= cur_ph_s[15:8] + 8'h40;
            pri1_r    <= p_r;
        end
    end

    // Stage 2: ROM data, clutter and noise sums; status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_I <= {width{1'b0}};
            signal_Q <= {width{1'b0}};
            rec_flag <= 1'b0;
            pri_idx  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LFM_ECHO_NOISE_EN
            lfsr_r   <= 16'hACE1;
`endif
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (state_r == FLUSH) && (next_state_s == GAP);
            if (valid1_r) begin
                rec_flag <= 1'b1;
                pri_idx  <= {{(8 - P_W){1'b0}}, pri1_r};
                if (win1_r) begin
                    signal_I <= CLUT + sine_of(cos_hi1_r) + noise_i_s;
                    signal_Q <= sine_of(sin_hi1_r) + noise_q_s;
                end else begin
                    signal_I <= CLUT + noise_i_s;
                    signal_Q <= noise_q_s;
                end
`ifdef LFM_ECHO_NOISE_EN
                lfsr_r <= lfsr_next(lfsr_r);
`endif
            end else begin
                rec_flag <= 1'b0;
                pri_idx  <= 8'h00;
                signal_I <= {width{1'b0}};
                signal_Q <= {width{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_lfm_echo_gen.sv
// Self-checking bench for lfm_echo_gen: directed dwells plus randomized ones,
// every sample compared against a closed-form reference of the chirp phase.
module tb_lfm_echo_gen;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [13:0]        tgt_delay = 14'd0;
    logic [15:0]        doppler_step = 16'd0;
    logic signed [11:0] signal_I, signal_Q;
    logic               rec_flag, busy, done;
    logic [7:0]         pri_idx;

    int checks = 0;
    int failures = 0;
    int tbl [0:64];
    int obs_i [0:8191];
    int obs_q [0:8191];
    logic [15:0] m_lfsr = 16'hACE1;

    lfm_echo_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tgt_delay(tgt_delay),
        .doppler_step(doppler_step), .signal_I(signal_I), .signal_Q(signal_Q),
        .rec_flag(rec_flag), .pri_idx(pri_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Signed waveform value for a 16-bit phase, quarter-wave rule.
    function automatic int wave(input int ph);
        int q, i;
        q = (ph >> 14) & 3;
        i = (ph >> 8) & 63;
        case (q)
            0: return tbl[i];
            1: return tbl[64 - i];
            2: return -tbl[i];
            default: return -tbl[64 - i];
        endcase
    endfunction

    // Expected sample: closed-form chirp phase at offset j into the echo window.
    task automatic model(input int s, input int p, input int d, input int dstep,
                         output int ei, output int eq);
        int j, ph;
        ei = 256;
        eq = 0;
        if (s >= d && s < d + 64) begin
            j  = s - d;
            ph = (p * dstep + j * 'h400 + 'h20 * ((j * (j - 1)) / 2)) & 'hFFFF;
            eq = wave(ph);
            ei = 256 + wave((ph + 'h4000) & 'hFFFF);
        end
`ifdef LFM_ECHO_NOISE_EN
        ei = ei + (m_lfsr[3] ? int'(m_lfsr[3:0]) - 16 : int'(m_lfsr[3:0]));
        eq = eq + (m_lfsr[7] ? int'(m_lfsr[7:4]) - 16 : int'(m_lfsr[7:4]));
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
    endtask

    task automatic run_dwell(input string name, input int dly, input int dstep,
                             input int stray_at, input int abort_at);
        int d_eff, k, lat, ei, eq, bad, dones, done_idx, zb, busy0, busy4;
        string fb;
        d_eff = (dly > 448) ? 448 : dly;
        @(negedge clk);
        start = 1'b1; tgt_delay = 14'(dly); doppler_step = 16'(dstep);
        @(negedge clk);
        start = 1'b0; tgt_delay = 14'($urandom); doppler_step = 16'($urandom);
        lat = 1;
        while (!rec_flag && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        k = 0; bad = 0; dones = 0; fb = "";
        while (rec_flag && k < 9000) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, "_abort_iq"}, int'(signal_I) | int'(signal_Q), 0);
                check({name, "_abort_flags"}, {rec_flag, busy, done, pri_idx}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                m_lfsr = 16'hACE1;
                @(negedge clk);
                check({name, "_abort_idle"}, {rec_flag, busy}, 0);
                return;
            end
            model(k % 512, k / 512, d_eff, dstep, ei, eq);
            obs_i[k] = int'(signal_I);
            obs_q[k] = int'(signal_Q);
            if (obs_i[k] != ei || obs_q[k] != eq || int'(pri_idx) != k / 512) begin
                if (bad == 0)
                    fb = $sformatf("k=%0d I=%0d/%0d Q=%0d/%0d p=%0d/%0d", k, obs_i[k], ei,
                                   obs_q[k], eq, pri_idx, k / 512);
                bad++;
            end
            if (done) dones++;
            start = (k == stray_at);
            tgt_delay = 14'($urandom);
            doppler_step = 16'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({name, "_rec_len"}, k, 8192);
        check($sformatf("%s_samples(first bad %s)", name, fb), bad, 0);
        zb = 0; done_idx = -1; busy0 = 0; busy4 = 1;
        for (int i = 0; i < 6; i++) begin
            if (done) begin dones++; done_idx = i; end
            if (i == 0) busy0 = busy;
            if (i == 4) busy4 = busy;
            if (signal_I != 0 || signal_Q != 0 || rec_flag || pri_idx != 0) zb++;
            @(negedge clk);
        end
        check({name, "_done_count"}, dones, 1);
        check({name, "_done_at_fall"}, done_idx, 0);
        check({name, "_busy_at_fall"}, busy0, 1);
        check({name, "_busy_low_after4"}, busy4, 0);
        check({name, "_zero_after"}, zb, 0);
    endtask

    initial begin
        int rep_bad, canc_bad, rd, rs;
        for (int i = 0; i <= 64; i++) tbl[i] = int'(1023.0 * $sin(i * 3.14159265358979 / 128.0));

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_iq", int'(signal_I) | int'(signal_Q), 0);
        check("reset_flags", {rec_flag, busy, done, pri_idx}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", {rec_flag, busy, done, pri_idx}, 0);

        // Clutter and echo position, stationary target.
        run_dwell("clutter", 100, 0, -1, -1);
        check("clut_s99_I", obs_i[3 * 512 + 99], 256 + 0);
`ifndef LFM_ECHO_NOISE_EN
        check("clut_s100_I", obs_i[3 * 512 + 100], 1279);
        check("clut_s100_Q", obs_q[3 * 512 + 100], 0);
        check("clut_s164_I", obs_i[7 * 512 + 164], 256);
        check("clut_s164_Q", obs_q[7 * 512 + 164], 0);
        rep_bad = 0; canc_bad = 0;
        for (int k = 512; k < 8192; k++) begin
            if (obs_i[k] != obs_i[k % 512] || obs_q[k] != obs_q[k % 512]) rep_bad++;
            if (k >= 1024 && (obs_i[k] - 2 * obs_i[k - 512] + obs_i[k - 1024] != 0 ||
                              obs_q[k] - 2 * obs_q[k - 512] + obs_q[k - 1024] != 0)) canc_bad++;
        end
        check("stationary_repeat", rep_bad, 0);
        check("canceller_zero", canc_bad, 0);
`endif

        // Doppler rotation by a quarter turn per PRI.
        run_dwell("doppler", 0, 'h4000, -1, -1);
`ifndef LFM_ECHO_NOISE_EN
        check("dop_p0_I", obs_i[0], 1279);    check("dop_p0_Q", obs_q[0], 0);
        check("dop_p1_I", obs_i[512], 256);   check("dop_p1_Q", obs_q[512], 1023);
        check("dop_p2_I", obs_i[1024], -767); check("dop_p2_Q", obs_q[1024], 0);
        check("dop_p3_I", obs_i[1536], 256);  check("dop_p3_Q", obs_q[1536], -1023);
        check("dop_p4_I", obs_i[2048], 1279); check("dop_p4_Q", obs_q[2048], 0);

        // Delay clamp, with a stray start pulse mid-dwell.
        run_dwell("clamp", 1000, 0, 2000, -1);
        check("clamp_s447_I", obs_i[5 * 512 + 447], 256);
        check("clamp_s448_I", obs_i[5 * 512 + 448], 1279);
`else
        run_dwell("clamp", 1000, 0, 2000, -1);
`endif

        // Reset mid-dwell, then a full fresh dwell with random parameters.
        run_dwell("abort", 100, 0, -1, 3000);
        rd = $urandom_range(0, 1023);
        rs = $urandom_range(0, 65535);
        run_dwell("after_abort", rd, rs, -1, -1);

        // Further randomized dwell.
        rd = $urandom_range(0, 1023);
        rs = $urandom_range(0, 65535);
        run_dwell("random", rd, rs, $urandom_range(0, 8000), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
